genius_jogo_param: RTL and testbench
====================================

Name: genius_jogo_param

Overview:
- Self-contained parametrised memory-game core ("Genius"): stores a one-hot button sequence, plays it back on LEDs, then checks the player's repetition round by round.
- Successor to the fixed 4-button / 16-round game top.
- Adds parametrised button count, round count and timing, in-circuit sequence generation, LED playback, and a mode where the player appends the next move.
- Sits between the board button/LED pins and the debug display decoders.

Parameters:
- N_BOTOES, 4, number of buttons/LEDs (2..8); memory word width.
- N_RODADAS, 16, maximum rounds; sequence memory depth.
- SHOW_CICLOS, 1000, clocks each LED stays lit, and dark, during playback.
- TIMEOUT_CICLOS, 5000, clocks allowed per move before timeout.

Ports:
- clock, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous, active-low reset.
- iniciar, in, 1, start/restart request.
- modo, in, 1, sampled in preparacao: 0 = generated sequence, 1 = player writes the next move.
- botoes, in, N_BOTOES, raw buttons, already synchronised.
- leds, out, N_BOTOES, playback word; zero otherwise.
- pronto, out, 1, game finished.
- ganhou, out, 1, all rounds completed.
- perdeu, out, 1, wrong move or timeout.
- timeout, out, 1, loss caused by timeout.
- db_tem_jogada, out, 1, botoes nonzero.
- db_estado, out, 4, state code.
- db_rodada, out, clog2(N_RODADAS), current round index.
- db_contagem, out, clog2(N_RODADAS), sequence address.
- db_memoria, out, N_BOTOES, mem[db_contagem].
- db_jogada, out, N_BOTOES, last registered move.

Behaviour:
- reset low: state inicial(0), all outputs, counters and the move register clear to 0; memory contents undefined.
- Generator: a counter g increments every clock, 0..N_BOTOES-1 and wraps. It is cleared only by reset. A generated word is one-hot(g) at the write cycle.
- Move detection: registered on the first clock botoes != 0 after a clock with botoes == 0. The value is latched as-is; non-one-hot never matches and so counts as an error.
- States and codes:
  - inicial(0): iniciar -> preparacao.
  - preparacao(1): rodada = 0, address = 0, timer = 0, outputs ganhou/perdeu/pronto/timeout clear, modo latched, mem[0] = one-hot(g) in both modes -> mostra.
  - mostra(2): leds = mem[address] for SHOW_CICLOS clocks -> apaga.
  - apaga(3): leds = 0 for SHOW_CICLOS clocks. If address == rodada: address = 0 -> espera; else address+1 -> mostra.
  - espera(4): timer counts; a move -> registra.
  - registra(5): latch the move, timer cleared -> compara.
  - compara(6):
    - mismatch -> errou.
    - match and address < rodada: address+1 -> espera.
    - match and address == rodada and rodada == N_RODADAS-1 -> acertou.
    - otherwise -> proxima.
  - proxima(7): modo 0: rodada+1, mem[rodada+1] = one-hot(g), address = 0 -> mostra. modo 1 -> espera_nova.
  - espera_nova(8): timer counts; a move -> grava_nova.
  - grava_nova(9): non-one-hot -> errou; else mem[rodada+1] = move, rodada+1, address = 0 -> mostra.
  - acertou(A): pronto = 1, ganhou = 1.
  - errou(E): pronto = 1, perdeu = 1.
  - fim_timeout(D): pronto = 1, perdeu = 1, timeout = 1.
  - All final states hold until iniciar, then -> preparacao.
- Timer: cleared on entry to espera/espera_nova. timer == TIMEOUT_CICLOS-1 while waiting -> fim_timeout. A move arriving on that same cycle is ignored; the timeout wins.
- iniciar is ignored outside inicial and the final states.
- A reset mid-game aborts immediately to inicial.
- Buttons held across a state change register no new move until released.

Optional Feature:
- Macro GENIUS_TIMEOUT_EN.
- Defined: timer and fim_timeout behave as above.
- Undefined: no timer logic, wait states never expire, timeout is tied to 0, and code D is unreachable.

Test Plan:
- N_BOTOES=4, N_RODADAS=4, SHOW=2, TIMEOUT=20; hold reset low mid-playback -> next clock db_estado=0, leds=0, pronto=0.
- modo 0: repeat each shown word (read via leds) for 4 rounds -> ganhou=1, pronto=1, db_rodada=3, state A; iniciar -> state 1.
- modo 0, round 1: press a word differing from mem[0] -> state E, perdeu=1, ganhou=0.
- Press botoes=4'b0011 in espera -> errou.
- modo 1: correct repeat, then press 4'b0100 -> mem[1]=4'b0100 and the playback of round 1 shows 0001-type word then 0100.
- GENIUS_TIMEOUT_EN: idle 20 clocks in espera -> state D, timeout=1, perdeu=1. Press on clock 19 -> still timeout.
- Without the macro: idle 1000 clocks -> stays in state 4.

Source files
------------

// File: rtl/genius_jogo_param_if.sv
// Pin-side bundle of the Genius game core: player controls, LED playback, result flags and debug taps.
interface genius_jogo_param_if #(
    parameter int unsigned N_BOTOES  = 4,
    parameter int unsigned N_RODADAS = 16
);
    localparam int unsigned RW = $clog2(N_RODADAS);

    logic                iniciar;
    logic                modo;
    logic [N_BOTOES-1:0] botoes;
    logic [N_BOTOES-1:0] leds;
    logic                pronto;
    logic                ganhou;
    logic                perdeu;
    logic                timeout;
    logic                db_tem_jogada;
    logic [3:0]          db_estado;
    logic [RW-1:0]       db_rodada;
    logic [RW-1:0]       db_contagem;
    logic [N_BOTOES-1:0] db_memoria;
    logic [N_BOTOES-1:0] db_jogada;

    modport master (
        output iniciar, modo, botoes,
        input  leds, pronto, ganhou, perdeu, timeout,
        input  db_tem_jogada, db_estado, db_rodada, db_contagem, db_memoria, db_jogada
    );

    modport slave (
        input  iniciar, modo, botoes,
        output leds, pronto, ganhou, perdeu, timeout,
        output db_tem_jogada, db_estado, db_rodada, db_contagem, db_memoria, db_jogada
    );
endinterface

// File: rtl/genius_jogo_param.sv
// Parametrised Genius memory-game core: generates/stores a one-hot sequence, plays it back, checks the player.
// Optional move timeout enabled by defining GENIUS_TIMEOUT_EN.
module genius_jogo_param #(
    parameter int unsigned N_BOTOES       = 4,
    parameter int unsigned N_RODADAS      = 16,
    parameter int unsigned SHOW_CICLOS    = 1000,
    parameter int unsigned TIMEOUT_CICLOS = 5000
) (
    input  logic clock,
    input  logic reset,
    genius_jogo_param_if.slave bus
);
    localparam int unsigned GW      = $clog2(N_BOTOES);
    localparam int unsigned RW      = $clog2(N_RODADAS);
    localparam int unsigned CNT_MAX = (SHOW_CICLOS > TIMEOUT_CICLOS) ? SHOW_CICLOS : TIMEOUT_CICLOS;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0, PREPARACAO = 4'h1, MOSTRA     = 4'h2, APAGA       = 4'h3,
        ESPERA      = 4'h4, REGISTRA   = 4'h5, COMPARA    = 4'h6, PROXIMA     = 4'h7,
        ESPERA_NOVA = 4'h8, GRAVA_NOVA = 4'h9, ACERTOU    = 4'hA, FIM_TIMEOUT = 4'hD,
        ERROU       = 4'hE
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [GW-1:0]       g_q;
    logic [N_BOTOES-1:0] botoes_prev_q, jogada_q, leds_q, db_mem_q;
    logic                modo_q, tem_q, pronto_q, ganhou_q, perdeu_q;
    logic [RW-1:0]       rodada_q, rodada_d, addr_q, addr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_BOTOES-1:0] mem [N_RODADAS];

    logic                mem_we, jogada_ld, modo_ld;
    logic [RW-1:0]       mem_waddr;
    logic [N_BOTOES-1:0] mem_wdata, gerado, mem_rd;
    logic                evento, show_fim, expira, match, fim_rodada;

    function automatic logic onehot(input logic [N_BOTOES-1:0] x);
        return (x != '0) && ((x & (x - N_BOTOES'(1))) == '0);
    endfunction

    assign gerado     = N_BOTOES'(1) << g_q;
    assign evento     = (bus.botoes != '0) && (botoes_prev_q == '0);
    assign show_fim   = cnt_q == CW'(SHOW_CICLOS - 1);
    assign match      = jogada_q == mem[addr_q];
    assign fim_rodada = addr_q == rodada_q;
    // Write-forwarding so playback/debug see a word written on the same edge
    assign mem_rd     = (mem_we && mem_waddr == addr_d) ? mem_wdata : mem[addr_d];
`ifdef GENIUS_TIMEOUT_EN
    assign expira     = cnt_q == CW'(TIMEOUT_CICLOS - 1);
`else
    assign expira     = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado_q <= INICIAL;
        else        estado_q <= estado_d;
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:     if (bus.iniciar) estado_d = PREPARACAO;
            PREPARACAO:  estado_d = MOSTRA;
            MOSTRA:      if (show_fim) estado_d = APAGA;
            APAGA:       if (show_fim) estado_d = fim_rodada ? ESPERA : MOSTRA;
            ESPERA:      if (expira) estado_d = FIM_TIMEOUT;
                         else if (evento) estado_d = REGISTRA;
            REGISTRA:    estado_d = COMPARA;
            COMPARA:     if (!match) estado_d = ERROU;
                         else if (!fim_rodada) estado_d = ESPERA;
                         else if (rodada_q == RW'(N_RODADAS - 1)) estado_d = ACERTOU;
                         else estado_d = PROXIMA;
            PROXIMA:     estado_d = modo_q ? ESPERA_NOVA : MOSTRA;
            ESPERA_NOVA: if (expira) estado_d = FIM_TIMEOUT;
                         else if (evento) estado_d = GRAVA_NOVA;
            GRAVA_NOVA:  estado_d = onehot(jogada_q) ? MOSTRA : ERROU;
            ACERTOU, ERROU, FIM_TIMEOUT: if (bus.iniciar) estado_d = PREPARACAO;
            default:     estado_d = INICIAL;
        endcase
    end

    // Datapath controls derived from the current state
    always_comb begin
        rodada_d  = rodada_q;
        addr_d    = addr_q;
        cnt_d     = '0;
        mem_we    = 1'b0;
        mem_waddr = rodada_q + RW'(1);
        mem_wdata = gerado;
        jogada_ld = 1'b0;
        modo_ld   = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                rodada_d  = '0;
                addr_d    = '0;
                mem_we    = 1'b1;
                mem_waddr = '0;
                modo_ld   = 1'b1;
            end
            MOSTRA: cnt_d = show_fim ? '0 : cnt_q + CW'(1);
            APAGA: begin
                cnt_d = show_fim ? '0 : cnt_q + CW'(1);
                if (show_fim) addr_d = fim_rodada ? '0 : addr_q + RW'(1);
            end
            ESPERA, ESPERA_NOVA: begin
`ifdef GENIUS_TIMEOUT_EN
                cnt_d = expira ? '0 : cnt_q + CW'(1);
`endif
                jogada_ld = evento && !expira;
            end
            COMPARA: if (match && !fim_rodada) addr_d = addr_q + RW'(1);
            PROXIMA: if (!modo_q) begin
                rodada_d = rodada_q + RW'(1);
                addr_d   = '0;
                mem_we   = 1'b1;
            end
            GRAVA_NOVA: if (onehot(jogada_q)) begin
                rodada_d  = rodada_q + RW'(1);
                addr_d    = '0;
                mem_we    = 1'b1;
                mem_wdata = jogada_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            g_q           <= '0;
            botoes_prev_q <= '0;
            jogada_q      <= '0;
            modo_q        <= 1'b0;
            rodada_q      <= '0;
            addr_q        <= '0;
            cnt_q         <= '0;
            leds_q        <= '0;
            db_mem_q      <= '0;
            tem_q         <= 1'b0;
            pronto_q      <= 1'b0;
            ganhou_q      <= 1'b0;
            perdeu_q      <= 1'b0;
        end else begin
            g_q           <= (g_q == GW'(N_BOTOES - 1)) ? '0 : g_q + GW'(1);
            botoes_prev_q <= bus.botoes;
            if (jogada_ld) jogada_q <= bus.botoes;
            if (modo_ld)   modo_q   <= bus.modo;
            rodada_q      <= rodada_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            leds_q        <= (estado_d == MOSTRA) ? mem_rd : '0;
            db_mem_q      <= mem_rd;
            tem_q         <= bus.botoes != '0;
            pronto_q      <= estado_d inside {ACERTOU, ERROU, FIM_TIMEOUT};
            ganhou_q      <= estado_d == ACERTOU;
            perdeu_q      <= estado_d inside {ERROU, FIM_TIMEOUT};
        end
    end

    // Sequence storage, contents undefined after reset
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

`ifdef GENIUS_TIMEOUT_EN
    logic timeout_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) timeout_q <= 1'b0;
        else        timeout_q <= estado_d == FIM_TIMEOUT;
    end
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.leds          = leds_q;
    assign bus.pronto        = pronto_q;
    assign bus.ganhou        = ganhou_q;
    assign bus.perdeu        = perdeu_q;
    assign bus.db_tem_jogada = tem_q;
    assign bus.db_estado     = estado_q;
    assign bus.db_rodada     = rodada_q;
    assign bus.db_contagem   = addr_q;
    assign bus.db_memoria    = db_mem_q;
    assign bus.db_jogada     = jogada_q;
endmodule

// File: tb/tb_genius_jogo_param.sv
// Directed bench for genius_jogo_param: 4 buttons, 4 rounds, 2-clock playback, 20-clock move timeout.
module tb_genius_jogo_param;
    localparam logic [3:0] S_INI = 4'h0, S_PREP = 4'h1, S_MOSTRA = 4'h2, S_APAGA = 4'h3,
                           S_ESP = 4'h4, S_ESPN = 4'h8, S_ACE = 4'hA, S_TO = 4'hD, S_ERR = 4'hE;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [3:0] shown [4];
    logic [3:0] seq   [4];
    logic [3:0] w_bad;

    genius_jogo_param_if #(.N_BOTOES(4), .N_RODADAS(4)) bus ();

    genius_jogo_param #(
        .N_BOTOES(4), .N_RODADAS(4), .SHOW_CICLOS(2), .TIMEOUT_CICLOS(20)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input string tag, input logic [3:0] code, input int budget);
        int k = 0;
        while (bus.db_estado !== code && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 8'(bus.db_estado), 8'(code));
    endtask

    task automatic start(input logic m);
        bus.modo    = m;
        bus.iniciar = 1'b1;
        @(negedge clk);
        bus.iniciar = 1'b0;
        check("start_prep", 8'(bus.db_estado), 8'(S_PREP));
    endtask

    // Record n played-back words; each lit word must be one-hot and dark phase must be 0
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            wait_state("wait_mostra", S_MOSTRA, 200);
            shown[i] = bus.leds;
            check("onehot_led", 8'($countones(shown[i]) == 1), 8'd1);
            wait_state("wait_apaga", S_APAGA, 200);
            check("apaga_dark", 8'(bus.leds), 8'h0);
        end
    endtask

    task automatic press(input logic [3:0] st, input logic [3:0] w);
        wait_state("wait_move", st, 200);
        bus.botoes = w;
        @(negedge clk);
        bus.botoes = 4'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.iniciar = 1'b0;
        bus.modo    = 1'b0;
        bus.botoes  = 4'b0;
        step(3);
        check("rst_estado", 8'(bus.db_estado), 8'(S_INI));
        check("rst_leds",   8'(bus.leds), 8'h0);
        check("rst_pronto", 8'(bus.pronto), 8'h0);
        check("rst_jogada", 8'(bus.db_jogada), 8'h0);
        rst_n = 1'b1;
        step(2);

        // Reset during playback aborts to inicial at once
        start(1'b0);
        wait_state("mid_mostra", S_MOSTRA, 20);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_estado", 8'(bus.db_estado), 8'(S_INI));
        check("midrst_leds",   8'(bus.leds), 8'h0);
        check("midrst_pronto", 8'(bus.pronto), 8'h0);
        rst_n = 1'b1;
        step(2);

        // Full win in generated mode
        start(1'b0);
        for (int r = 0; r < 4; r++) begin
            capture(r + 1);
            for (int i = 0; i < r; i++) check("replay_prefix", 8'(shown[i]), 8'(seq[i]));
            seq[r] = shown[r];
            for (int i = 0; i <= r; i++) press(S_ESP, seq[i]);
        end
        wait_state("win_state", S_ACE, 50);
        check("win_ganhou", 8'(bus.ganhou), 8'h1);
        check("win_pronto", 8'(bus.pronto), 8'h1);
        check("win_perdeu", 8'(bus.perdeu), 8'h0);
        check("win_rodada", 8'(bus.db_rodada), 8'h3);
        check("win_jogada", 8'(bus.db_jogada), 8'(seq[3]));

        // Wrong one-hot word in round 1
        start(1'b0);
        capture(1);
        seq[0] = shown[0];
        press(S_ESP, seq[0]);
        capture(2);
        check("r1_prefix", 8'(shown[0]), 8'(seq[0]));
        w_bad = (seq[0] == 4'b0001) ? 4'b0010 : 4'b0001;
        press(S_ESP, w_bad);
        wait_state("bad_state", S_ERR, 20);
        check("bad_perdeu", 8'(bus.perdeu), 8'h1);
        check("bad_ganhou", 8'(bus.ganhou), 8'h0);
        check("bad_pronto", 8'(bus.pronto), 8'h1);
        check("bad_timeout", 8'(bus.timeout), 8'h0);

        // Non-one-hot press never matches
        start(1'b0);
        capture(1);
        wait_state("nh_espera", S_ESP, 20);
        bus.botoes = 4'b0011;
        @(negedge clk);
        check("tem_jogada", 8'(bus.db_tem_jogada), 8'h1);
        bus.botoes = 4'b0;
        wait_state("nh_state", S_ERR, 20);
        check("nh_perdeu", 8'(bus.perdeu), 8'h1);
        check("nh_jogada", 8'(bus.db_jogada), 8'h3);

        // Player-written moves
        start(1'b1);
        capture(1);
        seq[0] = shown[0];
        press(S_ESP, seq[0]);
        press(S_ESPN, 4'b0100);
        capture(2);
        check("m1_word0", 8'(shown[0]), 8'(seq[0]));
        check("m1_word1", 8'(shown[1]), 8'h4);
        press(S_ESP, seq[0]);
        press(S_ESP, 4'b0100);
        wait_state("m1_espn", S_ESPN, 20);
        check("m1_rodada", 8'(bus.db_rodada), 8'h1);
        press(S_ESPN, 4'b0010);
        capture(3);
        check("m1_word2", 8'(shown[2]), 8'h2);
        wait_state("idle_espera", S_ESP, 20);
`ifdef GENIUS_TIMEOUT_EN
        step(19);
        check("to_before", 8'(bus.db_estado), 8'(S_ESP));
        step(1);
        check("to_state",   8'(bus.db_estado), 8'(S_TO));
        check("to_timeout", 8'(bus.timeout), 8'h1);
        check("to_perdeu",  8'(bus.perdeu), 8'h1);
        check("to_pronto",  8'(bus.pronto), 8'h1);

        // A move on the expiring clock loses to the timeout
        start(1'b0);
        capture(1);
        wait_state("late_espera", S_ESP, 20);
        step(19);
        bus.botoes = shown[0];
        @(negedge clk);
        bus.botoes = 4'b0;
        check("late_state",   8'(bus.db_estado), 8'(S_TO));
        check("late_timeout", 8'(bus.timeout), 8'h1);
`else
        step(1000);
        check("noto_state",   8'(bus.db_estado), 8'(S_ESP));
        check("noto_timeout", 8'(bus.timeout), 8'h0);
        check("noto_pronto",  8'(bus.pronto), 8'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
